// File: rtl/nios2_debug_vjtag_driver.sv
// nios2_debug_vjtag_driver
//   Turns one command into a full virtual-JTAG scan for the Nios II debug
//   slave: update-IR, capture-DR, DR_WIDTH-bit shift-DR, update-DR and
//   run-test-idle. vji_tck is generated from clk; one tck period is TCK_HALF
//   cycles low followed by TCK_HALF cycles high.
//
// Ports
//   clk, reset_n           system clock, synchronous active-low reset
//   cmd_valid/ready        command handshake; cmd_ir/cmd_dr carry the scan
//   rsp_valid/ready        result handshake; rsp_dr/rsp_ir hold the result
//   vji_tck/tdi/tdo        virtual test clock and serial data
//   vji_ir_in/ir_out       virtual instruction / slave status
//   vji_uir/cdr/sdr/udr    virtual TAP state strobes
//   vji_rti                run-test-idle (also high while idle)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command or for the result to be taken
// UIR   | update-IR, 1 tck period; vji_ir_out sampled on the tck rise
// CDR   | capture-DR, 1 tck period
// SDR   | shift-DR, DR_WIDTH tck periods, LSB first
// UDR   | update-DR, 1 tck period
// RTI   | run-test-idle, 1 tck period, then result posted
module nios2_debug_vjtag_driver #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_HALF = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int HW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DR_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [HW-1:0] HALF_LOAD = HW'(TCK_HALF - 1);
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI
  } state_t;

  state_t              state_q, state_d;
  logic                tck_q, tck_d;
  logic [HW-1:0]       half_q, half_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DR_WIDTH-1:0] sreg_q, sreg_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                tdi_q, tdi_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                ready_q, ready_d;
  logic                half_done, tck_rise, tck_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tck_q       <= 1'b0;
      half_q      <= '0;
      bit_q       <= '0;
      sreg_q      <= '0;
      rsp_dr_q    <= '0;
      rsp_ir_q    <= '0;
      ir_in_q     <= '0;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tck_q       <= tck_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      sreg_q      <= sreg_d;
      rsp_dr_q    <= rsp_dr_d;
      rsp_ir_q    <= rsp_ir_d;
      ir_in_q     <= ir_in_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tck_d       = tck_q;
    half_d      = half_q;
    bit_d       = bit_q;
    sreg_d      = sreg_q;
    rsp_dr_d    = rsp_dr_q;
    rsp_ir_d    = rsp_ir_q;
    ir_in_d     = ir_in_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;

    // Half-period timer reloads on every tck edge; tck never moves in IDLE.
    half_done = (half_q == '0);
    tck_rise  = (state_q != S_IDLE) && half_done && !tck_q;
    tck_fall  = (state_q != S_IDLE) && half_done && tck_q;

    if (state_q != S_IDLE) begin
      half_d = half_done ? HALF_LOAD : (half_q - HALF_ONE);
    end
    if (tck_rise) tck_d = 1'b1;
    if (tck_fall) tck_d = 1'b0;

    // State and tdi only change on the falling tck edge, giving the slave
    // a full half-period of setup and hold around each rising edge.
    case (state_q)
      S_IDLE: begin
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (cmd_valid && ready_q) begin
          state_d = S_UIR;
          sreg_d  = cmd_dr;
          ir_in_d = cmd_ir;
          half_d  = HALF_LOAD;
          tck_d   = 1'b0;
        end
      end
      S_UIR: begin
        if (tck_rise) rsp_ir_d = vji_ir_out;
        if (tck_fall) state_d = S_CDR;
      end
      S_CDR: begin
        if (tck_fall) begin
          state_d = S_SDR;
          bit_d   = '0;
          tdi_d   = sreg_q[0];
          sreg_d  = sreg_q >> 1;
        end
      end
      S_SDR: begin
        if (tck_rise) rsp_dr_d = {vji_tdo, rsp_dr_q[DR_WIDTH-1:1]};
        if (tck_fall) begin
          if (bit_q == BIT_LAST) begin
            state_d = S_UDR;
            tdi_d   = 1'b0;
          end else begin
            bit_d  = bit_q + BIT_ONE;
            tdi_d  = sreg_q[0];
            sreg_d = sreg_q >> 1;
          end
        end
      end
      S_UDR: begin
        if (tck_fall) state_d = S_RTI;
      end
      S_RTI: begin
        if (tck_fall) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so it stays low during reset and rises only the cycle
    // after the result handshake.
    ready_d = (state_d == S_IDLE) && !rsp_valid_d;
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign rsp_ir    = rsp_ir_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_in_q;
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SDR);
  assign vji_udr   = (state_q == S_UDR);
  assign vji_rti   = (state_q == S_RTI) || (state_q == S_IDLE);

endmodule

// File: tb/tb_nios2_debug_vjtag_driver.sv
// Testbench for nios2_debug_vjtag_driver: instance A (TCK_HALF=1) and
// instance B (TCK_HALF=3), each with a debug-slave data register model.
module tb_nios2_debug_vjtag_driver;
  localparam int DW    = 38;
  localparam int IW    = 2;
  localparam int LAT_A = 2 * 1 * (DW + 4);
  localparam int LAT_B = 2 * 3 * (DW + 4);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a;
  logic [IW-1:0] cmd_ir_a, rsp_ir_a, ir_in_a, ir_out_a;
  logic [DW-1:0] cmd_dr_a, rsp_dr_a;
  logic tck_a, tdi_a, tdo_a, uir_a, cdr_a, sdr_a, udr_a, rti_a;

  logic cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
  logic [IW-1:0] cmd_ir_b, rsp_ir_b, ir_in_b, ir_out_b;
  logic [DW-1:0] cmd_dr_b, rsp_dr_b;
  logic tck_b, tdi_b, tdo_b, uir_b, cdr_b, sdr_b, udr_b, rti_b;

  nios2_debug_vjtag_driver #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_HALF(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_ir(cmd_ir_a), .cmd_dr(cmd_dr_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_dr(rsp_dr_a), .rsp_ir(rsp_ir_a),
    .vji_tck(tck_a), .vji_tdi(tdi_a), .vji_tdo(tdo_a), .vji_ir_in(ir_in_a), .vji_ir_out(ir_out_a),
    .vji_uir(uir_a), .vji_cdr(cdr_a), .vji_sdr(sdr_a), .vji_udr(udr_a), .vji_rti(rti_a));

  nios2_debug_vjtag_driver #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_HALF(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_dr(rsp_dr_b), .rsp_ir(rsp_ir_b),
    .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_in_b), .vji_ir_out(ir_out_b),
    .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_rti(rti_b));

  // Slave data registers: optional preload on capture, shift on tck rise.
  // With preload disabled the register keeps the previous scan's data.
  logic [DW-1:0] slv_a, pre_a, slv_b, pre_b;
  logic pre_en_a, pre_en_b;
  always @(posedge tck_a) begin
    if (cdr_a && pre_en_a) slv_a <= pre_a;
    else if (sdr_a) slv_a <= {tdi_a, slv_a[DW-1:1]};
  end
  always @(posedge tck_b) begin
    if (cdr_b && pre_en_b) slv_b <= pre_b;
    else if (sdr_b) slv_b <= {tdi_b, slv_b[DW-1:1]};
  end
  assign tdo_a = slv_a[0];
  assign tdo_b = slv_b[0];

  logic [IW-1:0] cap_ir_in_a;
  logic [DW-1:0] cap_slv_a;
  int onehot_err = 0;
  logic prev_tck_b = 1'b0;
  logic run_ok_b = 1'b0;
  int run_b = 0, phase_err_b = 0, phase_cnt_b = 0, sdr_rise_b = 0;

  always @(negedge clk) begin
    if (uir_a) cap_ir_in_a <= ir_in_a;
    if (udr_a) cap_slv_a <= slv_a;
    if ($countones({uir_a, cdr_a, sdr_a, udr_a, rti_a}) > 1 ||
        $countones({uir_b, cdr_b, sdr_b, udr_b, rti_b}) > 1)
      onehot_err <= onehot_err + 1;
  end

  // tck phase lengths on B, for phases that start inside a scan.
  always @(negedge clk) begin
    prev_tck_b <= tck_b;
    if (tck_b != prev_tck_b) begin
      if (run_ok_b) begin
        phase_cnt_b <= phase_cnt_b + 1;
        if (run_b != 3) phase_err_b <= phase_err_b + 1;
      end
      run_b    <= 1;
      run_ok_b <= uir_b | cdr_b | sdr_b | udr_b;
      if (tck_b && sdr_b) sdr_rise_b <= sdr_rise_b + 1;
    end else begin
      run_b <= run_b + 1;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_a(input string nm);
    chk({nm, "_ctl"}, {tck_a, tdi_a, uir_a, cdr_a, sdr_a, udr_a, rti_a, cmd_ready_a, rsp_valid_a},
        9'b000000100);
    chk({nm, "_data"}, {rsp_dr_a, rsp_ir_a, ir_in_a}, 0);
  endtask

  task automatic start_a(input logic [IW-1:0] ir, input logic [DW-1:0] dr);
    int n = 0;
    while (!cmd_ready_a && n < 300) begin @(negedge clk); n++; end
    chk("ready_a_wait", cmd_ready_a, 1);
    cmd_ir_a = ir; cmd_dr_a = dr; cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  task automatic finish_a(output int lat);
    lat = 0;
    while (!rsp_valid_a && lat < 1000) begin @(negedge clk); lat++; end
  endtask

  task automatic ack_a;
    rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;
  endtask

  task automatic scan_a(input string nm, input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                        input logic pe, input logic [DW-1:0] pre, input logic [IW-1:0] irout,
                        input logic [DW-1:0] exp_dr);
    int lat;
    pre_en_a = pe; pre_a = pre; ir_out_a = irout;
    start_a(ir, dr);
    finish_a(lat);
    chk({nm, "_lat"}, lat, LAT_A);
    chk({nm, "_rsp_dr"}, rsp_dr_a, exp_dr);
    chk({nm, "_rsp_ir"}, rsp_ir_a, irout);
    chk({nm, "_ir_in"}, cap_ir_in_a, ir);
    chk({nm, "_slave_dr"}, cap_slv_a, dr);
    ack_a;
  endtask

  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] dr;
    logic          pe;
    logic [DW-1:0] pre;
    logic [IW-1:0] irout;
    logic [DW-1:0] exp_dr;
  } vec_t;

  vec_t tbl[6];
  logic [DW-1:0] model_slv;

  initial begin
    int lat, rv, s_rise, s_cnt, s_err;
    logic [63:0] r;
    logic [DW-1:0] dr, pre, dr2, pre2;
    logic [IW-1:0] ir, irout;
    logic pe;

    // Slave-register contents carried across loopback scans.
    tbl[0] = '{2'b01, 38'h2A_5555_AAAA, 1'b1, 38'h3F_0000_0001, 2'b10, 38'h3F_0000_0001};
    tbl[1] = '{2'b11, {DW{1'b1}},       1'b0, '0,               2'b01, 38'h2A_5555_AAAA};
    tbl[2] = '{2'b00, {DW{1'b0}},       1'b0, '0,               2'b11, {DW{1'b1}}};
    tbl[3] = '{2'b10, 38'h00_0000_0001, 1'b0, '0,               2'b00, {DW{1'b0}}};
    tbl[4] = '{2'b01, 38'h20_0000_0000, 1'b0, '0,               2'b10, 38'h00_0000_0001};
    tbl[5] = '{2'b10, 38'h00_0000_0000, 1'b0, '0,               2'b01, 38'h20_0000_0000};

    reset_n = 1'b0;
    cmd_valid_a = 1'b1; cmd_valid_b = 1'b1; rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    cmd_ir_a = 2'b11; cmd_dr_a = {DW{1'b1}}; cmd_ir_b = 2'b11; cmd_dr_b = {DW{1'b1}};
    ir_out_a = 2'b00; ir_out_b = 2'b00; pre_en_a = 1'b1; pre_en_b = 1'b1;
    pre_a = '0; pre_b = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_a("reset_hold");
      chk("reset_hold_b", {tck_b, uir_b, cmd_ready_b, rsp_valid_b, rti_b}, 5'b00001);
    end
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {cmd_ready_a, cmd_ready_b, uir_a, tck_a}, 4'b1100);

    for (int i = 0; i < 6; i++)
      scan_a($sformatf("vec%0d", i), tbl[i].ir, tbl[i].dr, tbl[i].pe, tbl[i].pre,
             tbl[i].irout, tbl[i].exp_dr);
    model_slv = tbl[5].dr;

    // Backpressure: result held 10 cycles while a second command waits.
    pre = 38'h15_A5A5_0F0F; pre2 = 38'h0A_1234_5678;
    dr = 38'h01_CAFE_F00D; dr2 = 38'h3E_DEAD_BEEF;
    pre_en_a = 1'b1; pre_a = pre; ir_out_a = 2'b11;
    start_a(2'b10, dr);
    finish_a(lat);
    chk("bp_lat1", lat, LAT_A);
    pre_a = pre2;
    cmd_ir_a = 2'b01; cmd_dr_a = dr2; cmd_valid_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid_a, cmd_ready_a, uir_a, tck_a}, 4'b1000);
      chk("bp_hold_dr", rsp_dr_a, pre);
    end
    rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;
    chk("bp_after_ack", {rsp_valid_a, cmd_ready_a, uir_a}, 3'b010);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    chk("bp_second_accept", {uir_a, cmd_ready_a}, 2'b10);
    finish_a(lat);
    chk("bp_lat2", lat, LAT_A);
    chk("bp_rsp_dr2", rsp_dr_a, pre2);
    chk("bp_slave_dr2", cap_slv_a, dr2);
    ack_a;

    // Reset during shift-DR bit 17.
    pre_en_a = 1'b1; pre_a = 38'h11_1111_1111; ir_out_a = 2'b01;
    dr = 38'h2B_3C4D_5E6F;
    start_a(2'b11, dr);
    repeat (39) @(negedge clk);
    chk("abort_in_sdr", {sdr_a, tck_a}, 2'b11);
    chk("abort_tdi_bit17", tdi_a, dr[17]);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_a("abort_reset");
    @(negedge clk);
    reset_n = 1'b1;
    rv = 0;
    repeat (100) begin @(negedge clk); if (rsp_valid_a) rv++; end
    chk("abort_no_rsp", rv, 0);
    scan_a("post_abort", 2'b01, 38'h2A_5555_AAAA, 1'b1, 38'h3F_0000_0001, 2'b10,
           38'h3F_0000_0001);
    model_slv = 38'h2A_5555_AAAA;

    // Random scans against the slave-register model.
    for (int i = 0; i < 10; i++) begin
      r = {$urandom, $urandom}; dr = r[DW-1:0];
      r = {$urandom, $urandom}; pre = r[DW-1:0];
      pe = 1'($urandom_range(0, 1));
      ir = IW'($urandom_range(0, 3));
      irout = IW'($urandom_range(0, 3));
      scan_a($sformatf("rand%0d", i), ir, dr, pe, pre, irout, pe ? pre : model_slv);
      model_slv = dr;
    end

    // TCK_HALF = 3 instance.
    pre_en_b = 1'b1; pre_b = 38'h3F_0000_0001; ir_out_b = 2'b10;
    s_rise = sdr_rise_b; s_cnt = phase_cnt_b; s_err = phase_err_b;
    rv = 0;
    while (!cmd_ready_b && rv < 300) begin @(negedge clk); rv++; end
    cmd_ir_b = 2'b01; cmd_dr_b = 38'h2A_5555_AAAA; cmd_valid_b = 1'b1;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    lat = 0;
    while (!rsp_valid_b && lat < 2000) begin @(negedge clk); lat++; end
    chk("b_lat", lat, LAT_B);
    chk("b_rsp_dr", rsp_dr_b, 38'h3F_0000_0001);
    chk("b_rsp_ir", rsp_ir_b, 2'b10);
    chk("b_slave_dr", slv_b, 38'h2A_5555_AAAA);
    chk("b_sdr_rises", sdr_rise_b - s_rise, DW);
    chk("b_phase_len_err", phase_err_b - s_err, 0);
    chk("b_phase_seen", (phase_cnt_b - s_cnt) >= 2 * DW, 1);
    rsp_ready_b = 1'b1;
    @(negedge clk);
    rsp_ready_b = 1'b0;
    chk("b_after_ack", {rsp_valid_b, cmd_ready_b}, 2'b01);

    chk("onehot_states", onehot_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
